multiplier: RTL and testbench
=============================

# multiplier

Sequential unsigned shift-add multiplier with valid/ready handshakes on both sides. It accepts two N-bit operands, computes their 2N-bit product over N clock cycles and holds the result until the downstream consumer takes it. It is a small arithmetic leaf block, used wherever a full combinational multiplier is too costly.

## Interface
- N, default 8: operand width in bits, N ≥ 1; product width is 2N.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-low.
- valid_i  input  1  upstream asserts when a and b carry a valid request.
- ready_i  output  1  block can accept a request this cycle.
- a  input  N  multiplicand, unsigned.
- b  input  N  multiplier, unsigned.
- valid_o  output  1  product is valid.
- ready_o  input  1  downstream can take the product this cycle.
- product  output  2N  registered result a*b, unsigned.

## Operation
- The state machine has three states: IDLE, BUSY, DONE.
- IDLE:
  - ready_i=1, valid_o=0.
  - On a clock edge with valid_i=1: register a zero-extended to 2N bits as the shifting multiplicand, register b as the shifting multiplier, clear the accumulator and the step counter, then go to BUSY.
- BUSY:
  - ready_i=0, valid_o=0.
  - Each edge performs one step:
    - if the multiplier LSB is 1, add the multiplicand to the accumulator (2N bits, cannot overflow);
    - shift the multiplicand left 1 and the multiplier right 1;
    - increment the counter.
  - After the N-th step, go to DONE with product = final accumulator.
  - Latency is always exactly N steps; there is no early exit when the multiplier becomes zero.
- DONE:
  - ready_i=0, valid_o=1, product held stable.
  - On an edge with ready_o=1, go to IDLE.
  - While ready_o=0, remain in DONE and hold product and valid_o.
- valid_i is ignored in BUSY and DONE. ready_i=0 in DONE means no new request overlaps a presented result.
- The block captures the operands at accept. Later changes on a and b do not affect the result in flight.
- product is registered. It keeps its last value in IDLE and BUSY, and is meaningful only while valid_o=1.
- Counter width is $clog2(N+1). N=1 must work (a single BUSY step).

## Timing
- Reset (rst=0, asynchronous, any state): state=IDLE, ready_i=1, valid_o=0, product=0, accumulator/shift registers/counter=0. This aborts any operation in flight with no output.
- Leaving reset: ready_i=1 on the first cycle.
- Accept edge = the edge in IDLE with valid_i=1.
- valid_o rises exactly N edges after the accept edge. ready_i is low from the accept edge until the edge that leaves DONE.
- Output handshake completes on the first edge in DONE with ready_o=1. With ready_o held high, valid_o is high for exactly one cycle.
- ready_i is high from the following cycle.
- Throughput with ready_o=1: one result every N+2 cycles (accept, N steps, DONE).
- All outputs are driven from registers or decoded from state only; there is no combinational path from inputs to outputs.

## Test plan
- Reset mid-BUSY:
  - N=3, accept 5*6, assert rst=0 one cycle later.
  - Required: valid_o=0, ready_i=1 and product=0 immediately, while clk is idle.
  - After release, accept 5*6 → product=30.
- Corner values (N=3):
  - 7*7 → 49 (0b110001);
  - 0*5 → 0;
  - 5*0 → 0;
  - 1*7 → 7.
  - Each with valid_o exactly 3 edges after accept.
- Operand stability: N=3, accept 5*3, then change a,b to 7,7 during BUSY → product=15.
- Backpressure:
  - N=3, ready_o=0, accept 6*3.
  - Required: valid_o stays 1 and product stays 18 for 5 cycles, ready_i stays 0, and a valid_i pulse is ignored.
  - Raise ready_o → IDLE next edge.
- Random regression: N=3, 1000 random operand pairs with ready_o=1. Required: product === a*b whenever valid_o=1, with zero mismatches.
- N=1 and N=8 builds:
  - N=1: 1*1 → 1, latency 1.
  - N=8: 255*255 → 65025, latency 8.

Source files
------------

// File: rtl/multiplier.sv
// Sequential unsigned shift-add multiplier: N-bit operands, 2N-bit product over
// N steps, with valid/ready handshakes on the request and result sides.
module multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_i,
  output logic           ready_i,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           valid_o,
  input  logic           ready_o,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2*N-1:0]   r_mcand;
  logic [N-1:0]     r_mplier;
  logic [2*N-1:0]   r_acc;
  logic [CW-1:0]    r_cnt;
  logic [2*N-1:0]   r_product;
  logic [2*N-1:0]   w_acc_next;
  logic             w_last;

  // One add-and-shift step; the final step's sum is what gets published.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {(2*N){1'b0}});
  assign w_last     = (r_cnt == CW'(N - 1));
  assign product    = r_product;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = valid_i ? S_BUSY : S_IDLE;
      S_BUSY:  w_next = w_last  ? S_DONE : S_BUSY;
      S_DONE:  w_next = ready_o ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    ready_i = 1'b0;
    valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_i = 1'b1;
        valid_o = 1'b0;
      end
      S_BUSY: begin
        ready_i = 1'b0;
        valid_o = 1'b0;
      end
      S_DONE: begin
        ready_i = 1'b0;
        valid_o = 1'b1;
      end
      default: begin
        ready_i = 1'b0;
        valid_o = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, shift-add steps and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand   <= {(2*N){1'b0}};
      r_mplier  <= {N{1'b0}};
      r_acc     <= {(2*N){1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_product <= {(2*N){1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_mcand  <= {{N{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= {(2*N){1'b0}};
            r_cnt    <= {CW{1'b0}};
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_product <= w_acc_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench: N=1, N=3 and N=8 instances checked against plain a*b
// and the handshake timing rules.
module tb_multiplier;

  logic       clk;
  logic       rst;
  logic [7:0] a_s [3];
  logic [7:0] b_s [3];
  logic [2:0] vi_s;
  logic [2:0] ro_s;
  wire  [2:0] ri_w;
  wire  [2:0] vo_w;
  wire  [1:0]  prod1;
  wire  [5:0]  prod3;
  wire  [15:0] prod8;
  logic [15:0] prod_s [3];

  int n_tests = 0;
  int n_fail  = 0;

  // index 0: N=1, index 1: N=3, index 2: N=8
  multiplier #(.N(1)) u_m1 (
    .clk(clk), .rst(rst), .valid_i(vi_s[0]), .ready_i(ri_w[0]),
    .a(a_s[0][0:0]), .b(b_s[0][0:0]), .valid_o(vo_w[0]), .ready_o(ro_s[0]),
    .product(prod1)
  );
  multiplier #(.N(3)) u_m3 (
    .clk(clk), .rst(rst), .valid_i(vi_s[1]), .ready_i(ri_w[1]),
    .a(a_s[1][2:0]), .b(b_s[1][2:0]), .valid_o(vo_w[1]), .ready_o(ro_s[1]),
    .product(prod3)
  );
  multiplier #(.N(8)) u_m8 (
    .clk(clk), .rst(rst), .valid_i(vi_s[2]), .ready_i(ri_w[2]),
    .a(a_s[2]), .b(b_s[2]), .valid_o(vo_w[2]), .ready_o(ro_s[2]),
    .product(prod8)
  );

  always_comb begin
    prod_s[0] = {14'd0, prod1};
    prod_s[1] = {10'd0, prod3};
    prod_s[2] = prod8;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full transaction on instance k with ready_o high; operands are scrambled
  // to (sa,sb) right after the accept edge.
  task automatic run(input int k, input int n, input int av, input int bv,
                     input int sa, input int sb, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, ".ready_before"}, ri_w[k], 1);
    a_s[k]  = av[7:0];
    b_s[k]  = bv[7:0];
    vi_s[k] = 1'b1;
    ro_s[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vi_s[k] = 1'b0;
    a_s[k]  = sa[7:0];
    b_s[k]  = sb[7:0];
    chk({tag, ".ready_low"}, ri_w[k], 0);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (vo_w[k]) break;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, ".latency"}, lat, n);
    chk({tag, ".product"}, prod_s[k], av * bv);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".valid_drop"}, vo_w[1 * k], 0);
    chk({tag, ".ready_back"}, ri_w[k], 1);
  endtask

  initial begin
    int av, bv, lat;
    rst  = 1'b0;
    vi_s = 3'b000;
    ro_s = 3'b111;
    for (int i = 0; i < 3; i++) begin
      a_s[i] = 8'd0;
      b_s[i] = 8'd0;
    end
    #1;
    chk("reset.ready", ri_w, 3'b111);
    chk("reset.valid", vo_w, 3'b000);
    chk("reset.product", prod3, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset.ready", ri_w[1], 1);

    // Corner values on N=3
    run(1, 3, 7, 7, 0, 0, "c7x7");
    run(1, 3, 0, 5, 7, 7, "c0x5");
    run(1, 3, 5, 0, 7, 7, "c5x0");
    run(1, 3, 1, 7, 6, 6, "c1x7");

    // Operand changes during BUSY must not matter
    run(1, 3, 5, 3, 7, 7, "stable");

    // Backpressure: result held, new request ignored
    @(negedge clk);
    ro_s[1] = 1'b0;
    a_s[1]  = 8'd6;
    b_s[1]  = 8'd3;
    vi_s[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vi_s[1] = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (vo_w[1]) break;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("bp.latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      vi_s[1] = (i == 2);
      a_s[1]  = 8'd7;
      b_s[1]  = 8'd7;
      @(posedge clk);
      @(negedge clk);
      chk("bp.valid", vo_w[1], 1);
      chk("bp.product", prod3, 18);
      chk("bp.ready", ri_w[1], 0);
    end
    vi_s[1] = 1'b0;
    ro_s[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp.exit_valid", vo_w[1], 0);
    chk("bp.exit_ready", ri_w[1], 1);

    // Reset during BUSY aborts the operation immediately
    @(negedge clk);
    a_s[1]  = 8'd5;
    b_s[1]  = 8'd6;
    vi_s[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vi_s[1] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_busy.valid", vo_w[1], 0);
    chk("rst_busy.ready", ri_w[1], 1);
    chk("rst_busy.product", prod3, 0);
    @(negedge clk);
    rst = 1'b1;
    run(1, 3, 5, 6, 1, 1, "after_rst");

    // Random regression on N=3
    for (int i = 0; i < 1000; i++) begin
      av = int'($urandom_range(0, 7));
      bv = int'($urandom_range(0, 7));
      run(1, 3, av, bv, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), "rand");
    end

    // N=1 and N=8 instances
    run(0, 1, 1, 1, 0, 0, "n1_1x1");
    run(0, 1, 0, 1, 1, 1, "n1_0x1");
    run(2, 8, 255, 255, 0, 0, "n8_255x255");
    run(2, 8, 200, 3, 255, 255, "n8_200x3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
